// File: rtl/apb_spi_regif.sv
// APB completer for the SPI block: CTRL/CLKDIV/STATUS/TXDATA/RXDATA register map.
// Latency: 1 setup + (WAIT_STATES + 1) access cycles; push/pop strobes follow completion by one cycle.
// Backpressure: PREADY held low for WAIT_STATES access cycles; a full TX FIFO or empty RX FIFO is reported on PSLVERR.
module apb_spi_regif #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 0,
    parameter int PRIV_ONLY   = 0
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [3:0]            pstrb,
    input  logic [2:0]            pprot,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [31:0]           ctrl,
    output logic [15:0]           clkdiv,
    output logic                  tx_push,
    output logic [7:0]            tx_data,
    input  logic                  tx_full,
    output logic                  rx_pop,
    input  logic [7:0]            rx_data,
    input  logic                  rx_empty,
    input  logic                  spi_busy
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state_q, state_cur, state_d;
    logic [3:0]  wait_q, wait_d;
    logic        complete;
    logic [31:0] rdata;
    logic        err;
    logic        push_d, pop_d;
    logic [31:0] ctrl_d;
    logic [15:0] clkdiv_d;
    logic [15:0] clk_merge;
    logic        unused_bits;

    assign unused_bits = ^{paddr[ADDR_WIDTH-1:5], paddr[1:0], pprot[2:1]};

    // A setup phase on the bus is recognised in the cycle it appears, so
    // back-to-back transfers and the first transfer after idle align alike.
    always_comb begin
        state_cur = state_q;
        if (psel && !penable)
            state_cur = SETUP;
    end

    always_comb begin
        state_d = state_cur;
        wait_d  = wait_q;
        case (state_cur)
            IDLE:  state_d = IDLE;
            SETUP: begin
                state_d = ACCESS;
                wait_d  = 4'(WAIT_STATES);
            end
            ACCESS: begin
                if (!psel) begin
                    state_d = IDLE;
                    wait_d  = 4'd0;
                end else if (wait_q != 4'd0) begin
                    wait_d = wait_q - 4'd1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pready   = !((state_cur == ACCESS) && (wait_q != 4'd0));
    assign complete = (state_cur == ACCESS) && psel && penable && (wait_q == 4'd0);

    always_comb begin
        clk_merge = clkdiv;
        if (pstrb[0]) clk_merge[7:0]  = pwdata[7:0];
        if (pstrb[1]) clk_merge[15:8] = pwdata[15:8];
    end

    always_comb begin
        rdata    = 32'h0;
        err      = 1'b0;
        push_d   = 1'b0;
        pop_d    = 1'b0;
        ctrl_d   = ctrl;
        clkdiv_d = clkdiv;
        if ((PRIV_ONLY != 0) && !pprot[0]) begin
            err = 1'b1;
        end else begin
            case (paddr[4:2])
                3'd0: begin
                    if (pwrite) begin
                        for (int i = 0; i < 4; i++)
                            if (pstrb[i]) ctrl_d[8*i +: 8] = pwdata[8*i +: 8];
                    end else begin
                        rdata = ctrl;
                    end
                end
                3'd1: begin
                    if (pwrite)
                        clkdiv_d = (clk_merge == 16'h0) ? 16'h1 : clk_merge;
                    else
                        rdata = {16'h0, clkdiv};
                end
                3'd2: begin
                    if (pwrite) err = 1'b1;
                    else        rdata = {29'h0, spi_busy, tx_full, rx_empty};
                end
                3'd3: begin
                    if (!pwrite || tx_full) err = 1'b1;
                    else                    push_d = pstrb[0];
                end
                3'd4: begin
                    if (pwrite || rx_empty) begin
                        err = 1'b1;
                    end else begin
                        rdata = {24'h0, rx_data};
                        pop_d = 1'b1;
                    end
                end
                default: err = 1'b1;
            endcase
        end
    end

    assign prdata  = complete ? rdata : 32'h0;
    assign pslverr = complete ? err : 1'b0;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
            wait_q  <= 4'd0;
            ctrl    <= 32'h0;
            clkdiv  <= 16'h4;
            tx_push <= 1'b0;
            tx_data <= 8'h0;
            rx_pop  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            tx_push <= complete && push_d;
            rx_pop  <= complete && pop_d;
            if (complete) begin
                ctrl   <= ctrl_d;
                clkdiv <= clkdiv_d;
                if (push_d) tx_data <= pwdata[7:0];
            end
        end
    end

endmodule

// File: tb/tb_apb_spi_regif.sv
// Bench for apb_spi_regif: two instances (2 wait states; 3 wait states with privileged-only access)
// driven by an APB requester and checked each cycle against a register-map model.
module tb_apb_spi_regif;

    logic        pclk = 1'b0;
    logic        preset_n;
    logic        psel[2], penable[2], pwrite[2];
    logic [31:0] paddr[2], pwdata[2], prdata[2], ctrl[2];
    logic [3:0]  pstrb[2];
    logic [2:0]  pprot[2];
    logic        pready[2], pslverr[2], tx_push[2], rx_pop[2];
    logic        tx_full[2], rx_empty[2], spi_busy[2];
    logic [15:0] clkdiv[2];
    logic [7:0]  tx_data[2], rx_data[2];

    logic [31:0] ctrl_m[2];
    logic [15:0] clk_m[2];
    logic [7:0]  txd_m[2];
    bit          exp_push[2], exp_pop[2], in_xfer[2];
    int          push_cnt[2], pop_cnt[2];
    int          n_cmp = 0, n_err = 0;

    always #5 pclk = ~pclk;

    apb_spi_regif #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(2), .PRIV_ONLY(0)) u0 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .pprot(pprot[0]), .prdata(prdata[0]),
        .pready(pready[0]), .pslverr(pslverr[0]), .ctrl(ctrl[0]), .clkdiv(clkdiv[0]),
        .tx_push(tx_push[0]), .tx_data(tx_data[0]), .tx_full(tx_full[0]), .rx_pop(rx_pop[0]),
        .rx_data(rx_data[0]), .rx_empty(rx_empty[0]), .spi_busy(spi_busy[0]));

    apb_spi_regif #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WAIT_STATES(3), .PRIV_ONLY(1)) u1 (
        .pclk(pclk), .preset_n(preset_n), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .pprot(pprot[1]), .prdata(prdata[1]),
        .pready(pready[1]), .pslverr(pslverr[1]), .ctrl(ctrl[1]), .clkdiv(clkdiv[1]),
        .tx_push(tx_push[1]), .tx_data(tx_data[1]), .tx_full(tx_full[1]), .rx_pop(rx_pop[1]),
        .rx_data(rx_data[1]), .rx_empty(rx_empty[1]), .spi_busy(spi_busy[1]));

    function automatic int ws(input int d);
        return (d == 1) ? 3 : 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Register-map rules: what a completed transfer must return and leave behind.
    task automatic model(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr,
                         output logic [31:0] rd, output bit err, output bit push, output bit pop,
                         output logic [31:0] nctrl, output logic [15:0] nclk);
        logic [31:0] off;
        logic [15:0] c;
        rd = 0; err = 0; push = 0; pop = 0;
        nctrl = ctrl_m[d]; nclk = clk_m[d];
        off = a & 32'h1C;
        if (d == 1 && pr[0] == 1'b0) begin
            err = 1;
        end else if (off == 32'h00) begin
            if (wr) begin
                for (int i = 0; i < 4; i++)
                    if (st[i]) nctrl = (nctrl & ~(32'hFF << (8*i))) | (wd & (32'hFF << (8*i)));
            end else rd = ctrl_m[d];
        end else if (off == 32'h04) begin
            if (wr) begin
                c = clk_m[d];
                if (st[0]) c = (c & 16'hFF00) | (wd[15:0] & 16'h00FF);
                if (st[1]) c = (c & 16'h00FF) | (wd[15:0] & 16'hFF00);
                nclk = (c == 0) ? 16'd1 : c;
            end else rd = 32'(clk_m[d]);
        end else if (off == 32'h08) begin
            if (wr) err = 1;
            else rd = 4 * 32'(spi_busy[d]) + 2 * 32'(tx_full[d]) + 32'(rx_empty[d]);
        end else if (off == 32'h0C) begin
            if (!wr || tx_full[d]) err = 1;
            else push = st[0];
        end else if (off == 32'h10) begin
            if (wr || rx_empty[d]) err = 1;
            else begin rd = 32'(rx_data[d]); pop = 1; end
        end else begin
            err = 1;
        end
    endtask

    always @(negedge pclk) begin
        if (preset_n) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("ctrl%0d", d), ctrl[d], ctrl_m[d]);
                chk($sformatf("clkdiv%0d", d), 32'(clkdiv[d]), 32'(clk_m[d]));
                chk($sformatf("tx_data%0d", d), 32'(tx_data[d]), 32'(txd_m[d]));
                chk($sformatf("tx_push%0d", d), 32'(tx_push[d]), 32'(exp_push[d]));
                chk($sformatf("rx_pop%0d", d), 32'(rx_pop[d]), 32'(exp_pop[d]));
                if (!in_xfer[d]) begin
                    chk($sformatf("idle_pready%0d", d), 32'(pready[d]), 32'd1);
                    chk($sformatf("idle_prdata%0d", d), prdata[d], 32'd0);
                    chk($sformatf("idle_pslverr%0d", d), 32'(pslverr[d]), 32'd0);
                end
            end
        end
    end

    always @(posedge pclk) begin
        for (int d = 0; d < 2; d++) begin
            if (tx_push[d]) push_cnt[d]++;
            if (rx_pop[d])  pop_cnt[d]++;
        end
    end

    task automatic setup_phase(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] st, input logic [2:0] pr);
        @(posedge pclk); #1;
        in_xfer[d] = 1; psel[d] = 1; penable[d] = 0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = wd; pstrb[d] = st; pprot[d] = pr;
        @(negedge pclk);
        chk("setup_pready", 32'(pready[d]), 32'd1);
        chk("setup_pslverr", 32'(pslverr[d]), 32'd0);
        @(posedge pclk); #1;
        penable[d] = 1;
    endtask

    task automatic apb(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr,
                       output logic [31:0] rd, output bit err);
        logic [31:0] mrd, nctrl;
        logic [15:0] nclk;
        bit merr, mpush, mpop;
        int cyc;
        setup_phase(d, wr, a, wd, st, pr);
        cyc = 0;
        forever begin
            @(negedge pclk);
            chk($sformatf("pready_seq%0d_c%0d", d, cyc), 32'(pready[d]), 32'(cyc >= ws(d)));
            if (pready[d]) break;
            if (cyc > 40) begin
                chk("pready_timeout", 32'd0, 32'd1);
                break;
            end
            cyc++;
        end
        model(d, wr, a, wd, st, pr, mrd, merr, mpush, mpop, nctrl, nclk);
        rd = prdata[d];
        err = pslverr[d];
        chk($sformatf("prdata%0d_a%02h", d, a[4:0]), prdata[d], mrd);
        chk($sformatf("pslverr%0d_a%02h", d, a[4:0]), 32'(pslverr[d]), 32'(merr));
        @(posedge pclk); #1;
        psel[d] = 0; penable[d] = 0; in_xfer[d] = 0;
        ctrl_m[d] = nctrl; clk_m[d] = nclk;
        if (mpush) txd_m[d] = wd[7:0];
        exp_push[d] = mpush; exp_pop[d] = mpop;
        @(posedge pclk); #1;
        exp_push[d] = 0; exp_pop[d] = 0;
    endtask

    task automatic reset_models();
        for (int d = 0; d < 2; d++) begin
            ctrl_m[d] = 0; clk_m[d] = 16'h4; txd_m[d] = 0;
            exp_push[d] = 0; exp_pop[d] = 0;
        end
    endtask

    initial begin
        logic [31:0] rd, a, wd;
        bit err;
        int pc, d;
        preset_n = 0;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 0; penable[i] = 0; pwrite[i] = 0; paddr[i] = 0; pwdata[i] = 0;
            pstrb[i] = 0; pprot[i] = 3'b001; tx_full[i] = 0; rx_empty[i] = 1;
            spi_busy[i] = 0; rx_data[i] = 0; in_xfer[i] = 0; push_cnt[i] = 0; pop_cnt[i] = 0;
        end
        reset_models();
        #12;
        for (int i = 0; i < 2; i++) begin
            chk("rst_pready", 32'(pready[i]), 32'd1);
            chk("rst_prdata", prdata[i], 32'd0);
            chk("rst_pslverr", 32'(pslverr[i]), 32'd0);
            chk("rst_ctrl", ctrl[i], 32'd0);
            chk("rst_clkdiv", 32'(clkdiv[i]), 32'h4);
            chk("rst_tx_push", 32'(tx_push[i]), 32'd0);
            chk("rst_tx_data", 32'(tx_data[i]), 32'd0);
            chk("rst_rx_pop", 32'(rx_pop[i]), 32'd0);
        end
        #10 preset_n = 1;

        apb(0, 0, 32'h0, 0, 4'h0, 3'b001, rd, err); chk("lit_ctrl_rst", rd, 32'h0);
        apb(0, 0, 32'h4, 0, 4'h0, 3'b001, rd, err); chk("lit_clkdiv_rst", rd, 32'h4);
        apb(0, 0, 32'h8, 0, 4'h0, 3'b001, rd, err); chk("lit_status", rd, 32'h1);
        chk("lit_status_err", 32'(err), 32'd0);
        apb(0, 1, 32'h0, 32'hA5A5_A5A5, 4'b0101, 3'b001, rd, err);
        chk("lit_ctrl_strb", ctrl[0], 32'h00A5_00A5);

        pc = push_cnt[0];
        apb(0, 1, 32'hC, 32'h1234_56C3, 4'hF, 3'b001, rd, err);
        chk("lit_txdata", 32'(tx_data[0]), 32'hC3);
        chk("lit_push_cnt", 32'(push_cnt[0] - pc), 32'd1);
        tx_full[0] = 1; pc = push_cnt[0];
        apb(0, 1, 32'hC, 32'h0000_0077, 4'hF, 3'b001, rd, err);
        chk("lit_txfull_err", 32'(err), 32'd1);
        chk("lit_txfull_nopush", 32'(push_cnt[0] - pc), 32'd0);
        tx_full[0] = 0;

        rx_data[0] = 8'h5A; rx_empty[0] = 0; pc = pop_cnt[0];
        apb(0, 0, 32'h10, 0, 4'h0, 3'b001, rd, err);
        chk("lit_rxdata", rd, 32'h5A);
        chk("lit_pop_cnt", 32'(pop_cnt[0] - pc), 32'd1);
        rx_empty[0] = 1; pc = pop_cnt[0];
        apb(0, 0, 32'h10, 0, 4'h0, 3'b001, rd, err);
        chk("lit_rxempty_err", 32'(err), 32'd1);
        chk("lit_rxempty_rd", rd, 32'd0);
        chk("lit_rxempty_nopop", 32'(pop_cnt[0] - pc), 32'd0);

        apb(0, 1, 32'h4, 32'h0, 4'h3, 3'b001, rd, err);
        apb(0, 0, 32'h4, 0, 4'h0, 3'b001, rd, err); chk("lit_clkdiv_zero", rd, 32'h1);
        apb(0, 0, 32'h18, 0, 4'h0, 3'b001, rd, err); chk("lit_0x18_err", 32'(err), 32'd1);
        apb(1, 0, 32'h0, 0, 4'h0, 3'b000, rd, err); chk("lit_priv_err", 32'(err), 32'd1);

        // Abort a TXDATA write on the 3-wait-state instance after one wait cycle.
        pc = push_cnt[1];
        setup_phase(1, 1, 32'hC, 32'h0000_00EE, 4'hF, 3'b001);
        @(negedge pclk);
        chk("abort_wait_pready", 32'(pready[1]), 32'd0);
        @(posedge pclk); #1;
        psel[1] = 0; penable[1] = 0;
        @(posedge pclk); #1;
        in_xfer[1] = 0;
        @(posedge pclk); #1;
        chk("abort_nopush", 32'(push_cnt[1] - pc), 32'd0);
        apb(1, 1, 32'h0, 32'h1357_9BDF, 4'hF, 3'b001, rd, err);
        chk("abort_then_ctrl", ctrl[1], 32'h1357_9BDF);

        for (int n = 0; n < 200; n++) begin
            d = n % 2;
            tx_full[d] = 1'($urandom); rx_empty[d] = 1'($urandom);
            spi_busy[d] = 1'($urandom); rx_data[d] = 8'($urandom);
            a = $urandom;
            a[4:2] = 3'($urandom_range(0, 7));
            wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            apb(d, 1'($urandom), a, wd, 4'($urandom), 3'($urandom), rd, err);
        end

        // Reset during a wait state of a TXDATA write.
        tx_full[0] = 0;
        apb(0, 1, 32'h0, 32'hDEAD_BEEF, 4'hF, 3'b001, rd, err);
        pc = push_cnt[0];
        setup_phase(0, 1, 32'hC, 32'h0000_0042, 4'hF, 3'b001);
        @(negedge pclk);
        #2 preset_n = 0;
        reset_models();
        #1;
        chk("rstmid_tx_push", 32'(tx_push[0]), 32'd0);
        chk("rstmid_pready", 32'(pready[0]), 32'd1);
        chk("rstmid_pslverr", 32'(pslverr[0]), 32'd0);
        chk("rstmid_prdata", prdata[0], 32'd0);
        chk("rstmid_ctrl", ctrl[0], 32'd0);
        chk("rstmid_clkdiv", 32'(clkdiv[0]), 32'h4);
        chk("rstmid_tx_data", 32'(tx_data[0]), 32'd0);
        @(posedge pclk); #1;
        psel[0] = 0; penable[0] = 0; in_xfer[0] = 0;
        @(negedge pclk); #2 preset_n = 1;
        repeat (3) @(posedge pclk);
        #1 chk("rstmid_nopush", 32'(push_cnt[0] - pc), 32'd0);
        apb(0, 0, 32'h4, 0, 4'h0, 3'b001, rd, err); chk("post_rst_clkdiv", rd, 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
